// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions used by the controller and the device-side responder:
// command encodings, mode-word field positions, address bit roles and error bit indices.
package sdram_pkg;

    // {cs, ras, cas, we}; cs=1 (deselect) is folded onto NOP by decode_cmd
    typedef enum logic [3:0] {
        CMD_LOAD_MODE = 4'b0000,
        CMD_REFRESH   = 4'b0001,
        CMD_PRECHARGE = 4'b0010,
        CMD_ACTIVE    = 4'b0011,
        CMD_WRITE     = 4'b0100,
        CMD_READ      = 4'b0101,
        CMD_TERMINATE = 4'b0110,
        CMD_NOP       = 4'b0111
    } sdram_cmd_e;

    // Mode word fields
    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BL_MSB = 2;
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_CL_MSB = 6;

    // Address bit roles
    localparam int A_COL_LSB       = 2;
    localparam int A_PRECHARGE_ALL = 10;

    // Deepest supported CAS latency, sizes the read pipeline
    localparam int CL_MAX = 3;

    // Sticky error bit indices
    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_CLOSED  = 1;
    localparam int ERR_MODE    = 2;
    localparam int ERR_TIMING  = 3;

    function automatic sdram_cmd_e decode_cmd(input logic cs, input logic ras,
                                              input logic cas, input logic we);
        if (cs) begin
            return CMD_NOP;
        end
        return sdram_cmd_e'({1'b0, ras, cas, we});
    endfunction

endpackage

// File: rtl/sdram_resp_rd_pipe.sv
// CAS-latency delay line plus burst address generator for the SDRAM responder.
// Presents the array read address and its valid flag one cycle before the
// read data register captures it.
module sdram_resp_rd_pipe
    import sdram_pkg::*;
#(
    parameter int BA_W  = 2,
    parameter int ROW_W = 4,
    parameter int COL_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cle,
    input  logic                          rd_start,
    input  logic [BA_W-1:0]               rd_ba,
    input  logic [ROW_W-1:0]              rd_row,
    input  logic [COL_W-1:0]              rd_col,
    input  logic [2:0]                    cl,
    input  logic [3:0]                    bl_beats,
    input  logic                          burst_stop,
    output logic [BA_W+ROW_W+COL_W-1:0]   arr_addr,
    output logic                          arr_valid,
    output logic [BA_W-1:0]               burst_ba
);

    localparam int DEPTH = CL_MAX;

    logic [DEPTH-1:0] p_valid;
    logic [BA_W-1:0]  p_ba  [DEPTH];
    logic [ROW_W-1:0] p_row [DEPTH];
    logic [COL_W-1:0] p_col [DEPTH];

    logic [BA_W-1:0]  b_ba;
    logic [ROW_W-1:0] b_row;
    logic [COL_W-1:0] b_col;
    logic [3:0]       b_left;

    logic [1:0]       load_idx;

    // Next column inside the aligned burst block (power-of-two beats)
    function automatic logic [COL_W-1:0] wrap_inc(input logic [COL_W-1:0] c,
                                                  input logic [3:0] beats);
        logic [COL_W-1:0] mask;
        mask = COL_W'(beats) - COL_W'(1);
        return (c & ~mask) | ((c + COL_W'(1)) & mask);
    endfunction

    // A READ enters at slot CL-1 so it reaches slot 0 after CL-1 shifts and
    // the output register captures it at the CL-th edge
    always_comb begin
        load_idx = (cl == 3'd2) ? 2'd1 : 2'd2;
    end

    // Delay line shift; a new READ overwrites whatever shifts into its slot
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid <= '0;
        end else if (cle) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                p_valid[i] <= p_valid[i+1];
                p_ba[i]    <= p_ba[i+1];
                p_row[i]   <= p_row[i+1];
                p_col[i]   <= p_col[i+1];
            end
            p_valid[DEPTH-1] <= 1'b0;
            if (rd_start) begin
                p_valid[load_idx] <= 1'b1;
                p_ba[load_idx]    <= rd_ba;
                p_row[load_idx]   <= rd_row;
                p_col[load_idx]   <= rd_col;
            end
        end
    end

    // Burst engine: beat 0 from the delay line restarts it, a stop clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            b_left <= '0;
        end else if (cle) begin
            if (p_valid[0]) begin
                b_ba   <= p_ba[0];
                b_row  <= p_row[0];
                b_col  <= wrap_inc(p_col[0], bl_beats);
                b_left <= bl_beats - 4'd1;
            end else if (burst_stop) begin
                b_left <= '0;
            end else if (b_left != '0) begin
                b_col  <= wrap_inc(b_col, bl_beats);
                b_left <= b_left - 4'd1;
            end
        end
    end

    // Beat 0 of a new READ takes precedence over the running burst
    always_comb begin
        arr_valid = p_valid[0] | (b_left != '0);
        arr_addr  = p_valid[0] ? {p_ba[0], p_row[0], p_col[0]} : {b_ba, b_row, b_col};
        burst_ba  = b_ba;
    end

endmodule

// File: rtl/sdram_responder.sv
// Device-side SDRAM model: decodes the controller's command bus, tracks bank
// state and mode, stores write data and returns read bursts after CAS latency.
// Optional macro SDRAM_RESP_TIMING_CHK_EN enables TRCD/TRP/TRFC checking (err[3]).
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int DQ_W         = 32,
    parameter int COL_W        = 8,
    parameter int MEM_ROW_BITS = 4,
    parameter int TRCD         = 3,
    parameter int TRP          = 3,
    parameter int TRFC         = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sdram_cle,
    input  logic            sdram_cs,
    input  logic            sdram_ras,
    input  logic            sdram_cas,
    input  logic            sdram_we,
    input  logic            sdram_dqm,
    input  logic [1:0]      sdram_ba,
    input  logic [12:0]     sdram_a,
    input  logic [DQ_W-1:0] sdram_dqo,
    output logic [DQ_W-1:0] sdram_dqi,
    output logic            rd_valid,
    output logic            mode_loaded,
    output logic [15:0]     refresh_cnt,
    output logic [3:0]      err
);

    localparam int BA_W      = 2;
    localparam int AW        = BA_W + MEM_ROW_BITS + COL_W;
    localparam int MEM_DEPTH = 1 << AW;

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e                  state, state_nxt;
    sdram_cmd_e              cmd;
    logic [3:0]              bank_open;
    logic [MEM_ROW_BITS-1:0] bank_row [4];
    logic [2:0]              cl_q, cl_new, cl_field;
    logic [3:0]              bl_q, bl_new;
    logic [2:0]              bl_field;
    logic                    mode_ok;
    logic                    do_load_mode, do_active, do_read, do_write;
    logic                    do_precharge, do_refresh, do_terminate;
    logic                    burst_stop;
    logic [ERR_MODE:0]       err_set;
    logic                    timing_viol;
    logic [COL_W-1:0]        col;
    logic [AW-1:0]           arr_addr;
    logic                    arr_valid;
    logic [BA_W-1:0]         burst_ba;
    logic [DQ_W-1:0]         mem [MEM_DEPTH];
    logic                    unused_a_hi;

    assign col         = sdram_a[A_COL_LSB +: COL_W];
    assign cl_field    = sdram_a[MODE_CL_MSB:MODE_CL_LSB];
    assign bl_field    = sdram_a[MODE_BL_MSB:MODE_BL_LSB];
    assign mode_ok     = ((cl_field == 3'd2) || (cl_field == 3'd3)) && !bl_field[2];
    assign unused_a_hi = ^sdram_a[12:11];

    // Clock enable low makes every edge look like a NOP
    always_comb begin
        cmd = sdram_cle ? decode_cmd(sdram_cs, sdram_ras, sdram_cas, sdram_we) : CMD_NOP;
    end

    // Top state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Command legality, next state and per-command actions
    always_comb begin
        state_nxt    = state;
        do_load_mode = 1'b0;
        do_active    = 1'b0;
        do_read      = 1'b0;
        do_write     = 1'b0;
        do_precharge = 1'b0;
        do_refresh   = 1'b0;
        do_terminate = 1'b0;
        err_set      = '0;
        cl_new       = 3'd3;
        bl_new       = 4'd1;
        case (cmd)
            CMD_LOAD_MODE: begin
                if (state == ST_INIT || bank_open == '0) begin
                    do_load_mode = 1'b1;
                    state_nxt    = ST_READY;
                    if (mode_ok) begin
                        cl_new = cl_field;
                        bl_new = 4'b0001 << bl_field[1:0];
                    end else begin
                        err_set[ERR_MODE] = 1'b1;
                    end
                end else begin
                    err_set[ERR_ILLEGAL] = 1'b1;
                end
            end
            CMD_PRECHARGE: do_precharge = 1'b1;
            CMD_REFRESH: begin
                do_refresh = 1'b1;
                if (bank_open != '0) begin
                    err_set[ERR_ILLEGAL] = 1'b1;
                end
            end
            CMD_ACTIVE: begin
                if (state == ST_INIT || bank_open[sdram_ba]) begin
                    err_set[ERR_ILLEGAL] = 1'b1;
                end else begin
                    do_active = 1'b1;
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (state == ST_INIT) begin
                    err_set[ERR_ILLEGAL] = 1'b1;
                end else if (!bank_open[sdram_ba]) begin
                    err_set[ERR_CLOSED] = 1'b1;
                end else if (cmd == CMD_READ) begin
                    do_read = 1'b1;
                end else begin
                    do_write = 1'b1;
                end
            end
            CMD_TERMINATE: begin
                if (state == ST_INIT) begin
                    err_set[ERR_ILLEGAL] = 1'b1;
                end else begin
                    do_terminate = 1'b1;
                end
            end
            default: ;
        endcase
        burst_stop = do_terminate | do_write |
                     (do_precharge & (sdram_a[A_PRECHARGE_ALL] | (sdram_ba == burst_ba)));
    end

    // Mode, bank table, refresh counter and sticky errors
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open   <= '0;
            mode_loaded <= 1'b0;
            refresh_cnt <= '0;
            err         <= '0;
            cl_q        <= 3'd3;
            bl_q        <= 4'd1;
        end else begin
            err <= err | {timing_viol, err_set};
            if (do_load_mode) begin
                mode_loaded <= 1'b1;
                cl_q        <= cl_new;
                bl_q        <= bl_new;
            end
            if (do_active) begin
                bank_open[sdram_ba] <= 1'b1;
                bank_row[sdram_ba]  <= sdram_a[MEM_ROW_BITS-1:0];
            end
            if (do_precharge) begin
                if (sdram_a[A_PRECHARGE_ALL]) begin
                    bank_open <= '0;
                end else begin
                    bank_open[sdram_ba] <= 1'b0;
                end
            end
            if (do_refresh) begin
                refresh_cnt <= refresh_cnt + 16'd1;
            end
        end
    end

    // Storage array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && do_write && !sdram_dqm) begin
            mem[{sdram_ba, bank_row[sdram_ba], col}] <= sdram_dqo;
        end
    end

    sdram_resp_rd_pipe #(
        .BA_W  (BA_W),
        .ROW_W (MEM_ROW_BITS),
        .COL_W (COL_W)
    ) u_rd_pipe (
        .clk        (clk),
        .rst        (rst),
        .cle        (sdram_cle),
        .rd_start   (do_read),
        .rd_ba      (sdram_ba),
        .rd_row     (bank_row[sdram_ba]),
        .rd_col     (col),
        .cl         (cl_q),
        .bl_beats   (bl_q),
        .burst_stop (burst_stop),
        .arr_addr   (arr_addr),
        .arr_valid  (arr_valid),
        .burst_ba   (burst_ba)
    );

    // Read data register; zero whenever no beat is presented
    always_ff @(posedge clk) begin
        if (rst) begin
            sdram_dqi <= '0;
            rd_valid  <= 1'b0;
        end else if (sdram_cle) begin
            rd_valid  <= arr_valid;
            sdram_dqi <= arr_valid ? mem[arr_addr] : '0;
        end
    end

`ifdef SDRAM_RESP_TIMING_CHK_EN
    localparam int TCNT_W = $clog2(TRCD + TRP + TRFC + 1);

    logic [TCNT_W-1:0] trcd_cnt [4];
    logic [TCNT_W-1:0] trp_cnt  [4];
    logic [TCNT_W-1:0] trfc_cnt;

    // Remaining-cycles counters, loaded with Tx-1 so the command Tx edges later is legal
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned b = 0; b < 4; b++) begin
                trcd_cnt[b] <= '0;
                trp_cnt[b]  <= '0;
            end
            trfc_cnt <= '0;
        end else if (sdram_cle) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (do_active && sdram_ba == BA_W'(b)) begin
                    trcd_cnt[b] <= TCNT_W'(TRCD - 1);
                end else if (trcd_cnt[b] != '0) begin
                    trcd_cnt[b] <= trcd_cnt[b] - TCNT_W'(1);
                end
                if (do_precharge && (sdram_a[A_PRECHARGE_ALL] || sdram_ba == BA_W'(b))) begin
                    trp_cnt[b] <= TCNT_W'(TRP - 1);
                end else if (trp_cnt[b] != '0) begin
                    trp_cnt[b] <= trp_cnt[b] - TCNT_W'(1);
                end
            end
            if (do_refresh) begin
                trfc_cnt <= TCNT_W'(TRFC - 1);
            end else if (trfc_cnt != '0) begin
                trfc_cnt <= trfc_cnt - TCNT_W'(1);
            end
        end
    end

    // Flag commands issued before their bank or refresh window has elapsed
    always_comb begin
        timing_viol = 1'b0;
        if ((do_read || do_write) && trcd_cnt[sdram_ba] != '0) begin
            timing_viol = 1'b1;
        end
        if (do_active && trp_cnt[sdram_ba] != '0) begin
            timing_viol = 1'b1;
        end
        if (cmd != CMD_NOP && trfc_cnt != '0) begin
            timing_viol = 1'b1;
        end
    end
`else
    logic unused_timing_cfg;
    assign unused_timing_cfg = (TRCD + TRP + TRFC) > 0;
    assign timing_viol       = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Directed self-checking bench for sdram_responder.
module tb_sdram_responder;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_TERM = 4'b0110;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_LMR  = 4'b0000;

`ifdef SDRAM_RESP_TIMING_CHK_EN
    localparam logic [3:0] TERR = 4'b1000;
`else
    localparam logic [3:0] TERR = 4'b0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cle = 1'b1;
    logic        cs  = 1'b0;
    logic        ras = 1'b1;
    logic        cas = 1'b1;
    logic        we  = 1'b1;
    logic        dqm = 1'b0;
    logic [1:0]  ba  = '0;
    logic [12:0] a   = '0;
    logic [31:0] dqo = '0;
    logic [31:0] dqi;
    logic        rd_valid;
    logic        mode_loaded;
    logic [15:0] refresh_cnt;
    logic [3:0]  err;

    int vectors     = 0;
    int miscompares = 0;
    int beats;

    always #5 clk = ~clk;

    sdram_responder #(
        .DQ_W         (32),
        .COL_W        (8),
        .MEM_ROW_BITS (4),
        .TRCD         (3),
        .TRP          (3),
        .TRFC         (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sdram_cle   (cle),
        .sdram_cs    (cs),
        .sdram_ras   (ras),
        .sdram_cas   (cas),
        .sdram_we    (we),
        .sdram_dqm   (dqm),
        .sdram_ba    (ba),
        .sdram_a     (a),
        .sdram_dqo   (dqo),
        .sdram_dqi   (dqi),
        .rd_valid    (rd_valid),
        .mode_loaded (mode_loaded),
        .refresh_cnt (refresh_cnt),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One command on one edge; outputs are sampled 1 ns after that edge
    task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] addr,
                         input logic [31:0] d, input logic m);
        {cs, ras, cas, we} = c;
        ba  = b;
        a   = addr;
        dqo = d;
        dqm = m;
        @(posedge clk);
        #1;
        {cs, ras, cas, we} = C_NOP;
        dqm = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_valid", rd_valid, 0);
        check("rst_dqi", dqi, 0);
        check("rst_mode", mode_loaded, 0);
        check("rst_refcnt", refresh_cnt, 0);
        check("rst_err", err, 0);

        // READ before LOAD_MODE is illegal
        drive(C_RD, 2'd0, 13'h000, 32'h0, 1'b0);
        check("init_read_err", err, 4'b0001);
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            beats += int'(rd_valid);
        end
        check("init_read_beats", beats, 0);
        do_reset();
        check("rst2_err", err, 0);

        // Test 1: CL=2 BL=4, write then read one word
        drive(C_LMR, 2'd0, 13'h022, 32'h0, 1'b0);
        check("mode_loaded", mode_loaded, 1);
        drive(C_ACT, 2'd1, 13'h005, 32'h0, 1'b0);
        idle(3);
        drive(C_WR, 2'd1, 13'h040, 32'hDEADBEEF, 1'b0);
        drive(C_RD, 2'd1, 13'h040, 32'h0, 1'b0);
        check("t1_valid_n0", rd_valid, 0);
        idle(1);
        check("t1_valid_n1", rd_valid, 0);
        idle(1);
        check("t1_valid_n2", rd_valid, 1);
        check("t1_data", dqi, 32'hDEADBEEF);
        idle(4);
        check("t1_err", err, 0);

        // Test 2: wrapped burst read starting at col 6
        drive(C_WR, 2'd1, 13'h010, 32'hA, 1'b0);
        drive(C_WR, 2'd1, 13'h014, 32'hB, 1'b0);
        drive(C_WR, 2'd1, 13'h018, 32'hC, 1'b0);
        drive(C_WR, 2'd1, 13'h01C, 32'hD, 1'b0);
        drive(C_WR, 2'd1, 13'h010, 32'hEEEE, 1'b1);
        drive(C_RD, 2'd1, 13'h018, 32'h0, 1'b0);
        idle(1);
        check("t2_valid_pre", rd_valid, 0);
        idle(1);
        check("t2_beat0", dqi, 32'hC);
        idle(1);
        check("t2_beat1", dqi, 32'hD);
        idle(1);
        check("t2_beat2_masked_wr", dqi, 32'hA);
        idle(1);
        check("t2_beat3", dqi, 32'hB);
        idle(1);
        check("t2_valid_post", rd_valid, 0);
        check("t2_dqi_post", dqi, 0);

        // Clock enable low freezes the burst mid-way
        drive(C_RD, 2'd1, 13'h018, 32'h0, 1'b0);
        idle(2);
        check("cle_beat0", dqi, 32'hC);
        cle = 1'b0;
        idle(2);
        check("cle_hold_valid", rd_valid, 1);
        check("cle_hold_data", dqi, 32'hC);
        cle = 1'b1;
        idle(1);
        check("cle_beat1", dqi, 32'hD);
        idle(1);
        check("cle_beat2", dqi, 32'hA);
        idle(1);
        check("cle_beat3", dqi, 32'hB);
        idle(1);
        check("cle_end", rd_valid, 0);

        // Test 4: TERMINATE one cycle after beat 0 leaves two beats
        beats = 0;
        drive(C_RD, 2'd1, 13'h010, 32'h0, 1'b0);
        idle(1);
        beats += int'(rd_valid);
        idle(1);
        beats += int'(rd_valid);
        check("t4_beat0", dqi, 32'hA);
        drive(C_TERM, 2'd0, 13'h000, 32'h0, 1'b0);
        beats += int'(rd_valid);
        check("t4_beat1", dqi, 32'hB);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            beats += int'(rd_valid);
        end
        check("t4_beats", beats, 2);
        check("t4_dqi_zero", dqi, 0);

        // Test 3: READ to a closed bank
        drive(C_RD, 2'd2, 13'h000, 32'h0, 1'b0);
        check("t3_err", err, 4'b0010);
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            beats += int'(rd_valid);
        end
        check("t3_beats", beats, 0);

        // Test 5: refresh counting
        drive(C_PRE, 2'd0, 13'h400, 32'h0, 1'b0);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            drive(C_REF, 2'd0, 13'h000, 32'h0, 1'b0);
            idle(7);
        end
        check("t5_refcnt3", refresh_cnt, 3);
        check("t5_err_clean", err, 4'b0010);
        drive(C_ACT, 2'd0, 13'h001, 32'h0, 1'b0);
        drive(C_REF, 2'd0, 13'h000, 32'h0, 1'b0);
        check("t5_refcnt4", refresh_cnt, 4);
        check("t5_err_open", err, 4'b0011);

        // Bad mode word falls back to CL=3, BL=1
        do_reset();
        check("rst3_refcnt", refresh_cnt, 0);
        drive(C_LMR, 2'd0, 13'h010, 32'h0, 1'b0);
        check("bad_mode_err", err, 4'b0100);
        check("bad_mode_loaded", mode_loaded, 1);
        drive(C_ACT, 2'd0, 13'h001, 32'h0, 1'b0);
        idle(3);
        drive(C_WR, 2'd0, 13'h008, 32'h12345678, 1'b0);
        drive(C_RD, 2'd0, 13'h008, 32'h0, 1'b0);
        idle(2);
        check("cl3_valid_n2", rd_valid, 0);
        idle(1);
        check("cl3_valid_n3", rd_valid, 1);
        check("cl3_data", dqi, 32'h12345678);
        idle(1);
        check("bl1_end", rd_valid, 0);

        // Test 6: READ one cycle after ACTIVE
        drive(C_ACT, 2'd1, 13'h002, 32'h0, 1'b0);
        drive(C_RD, 2'd1, 13'h000, 32'h0, 1'b0);
        check("t6_timing_err", err, 4'b0100 | TERR);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
